ccip_mmio_avmm_requestor: RTL and testbench

CCIP_MMIO_AVMM_REQUESTOR -- requirements
Module: ccip_mmio_avmm_requestor

---
 rtl/ccip_avmm_pkg.sv | 75 +++++++
 rtl/ccip_avmm_mmio_fifo.sv | 64 ++++++
 rtl/ccip_mmio_avmm_requestor.sv | 208 ++++++++++++++++++++
 tb/tb_ccip_mmio_avmm_requestor.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccip_avmm_pkg.sv
// ----------------------------------------------------------------------------
// ccip_avmm_pkg
// Shared types and constants for the CCI-P MMIO to Avalon-MM requestor.
//   - CCIP_AVMM_MMIO_ADDR_WIDTH : AVMM byte-address width
//   - MMIO_LEN_*                : CCI-P MMIO length encodings
//   - t_if_ccip_c0_Rx / t_if_ccip_c2_Tx : reduced CCI-P channel structs
//     carrying only the MMIO fields this block uses
//   - t_mmio_req_entry          : request FIFO entry
//   - t_mmio_tid_entry          : outstanding-read FIFO entry
//   - t_ctl_state               : controller FSM states
// ----------------------------------------------------------------------------
package ccip_avmm_pkg;

    localparam int CCIP_AVMM_MMIO_ADDR_WIDTH = 18;

    localparam logic [1:0] MMIO_LEN_4B  = 2'b00;
    localparam logic [1:0] MMIO_LEN_8B  = 2'b01;
    localparam logic [1:0] MMIO_LEN_64B = 2'b10;

    typedef struct packed {
        logic [15:0] address;   // 4B-granule MMIO address
        logic [1:0]  length;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [63:0]         data;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        logic        is_rd;
        logic [15:0] addr;
        logic [1:0]  length;
        logic [8:0]  tid;
        logic [63:0] data;
    } t_mmio_req_entry;

    typedef struct packed {
        logic [8:0] tid;
        logic       addr0;
        logic [1:0] length;
    } t_mmio_tid_entry;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } t_ctl_state;

    // Only 4B and 8B accesses map onto a single 64-bit AVMM beat; 64B and
    // the reserved encoding are dropped.
    function automatic logic mmio_len_supported(input logic [1:0] len);
        return (len == MMIO_LEN_4B) || (len == MMIO_LEN_8B);
    endfunction

    function automatic logic [7:0] mmio_byteenable(input logic addr0, input logic [1:0] len);
        if (len == MMIO_LEN_4B) begin
            return addr0 ? 8'hF0 : 8'h0F;
        end
        return 8'hFF;
    endfunction

endpackage

// File: rtl/ccip_avmm_mmio_fifo.sv
// ----------------------------------------------------------------------------
// ccip_avmm_mmio_fifo
// Show-ahead synchronous FIFO: rdata_o always presents the oldest entry
// while empty_o is low. Push when full and pop when empty are ignored.
// Ports:
//   clk, reset_n        clock, async active-low reset (pointers only)
//   push_i, wdata_i     write strobe and data
//   pop_i               consume head entry
//   rdata_o             head entry
//   full_o, empty_o     status
// DEPTH must be a power of two.
// ----------------------------------------------------------------------------
module ccip_avmm_mmio_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    // Extra pointer bit distinguishes full from empty.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/ccip_mmio_avmm_requestor.sv
// ----------------------------------------------------------------------------
// ccip_mmio_avmm_requestor
// Converts CCI-P host MMIO requests into Avalon-MM commands and returns MMIO
// read data on c2.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   c0rx                    host MMIO rd/wr requests
//   c2tx                    MMIO read responses (registered)
//   avmm_address            64-bit-aligned byte address
//   avmm_read/avmm_write    commands, held while avmm_waitrequest=1
//   avmm_writedata/byteenable
//   avmm_waitrequest, avmm_readdata, avmm_readdatavalid
//   mmio_overflow           sticky: request dropped (FIFO full or 64B)
// Build option: define MMIO_RD_TIMEOUT_EN to answer reads that get no
// readdatavalid within RD_TIMEOUT_CYCLES with all-ones data.
//
// Controller FSM
//   state    | meaning
//   ST_IDLE  | no command on AVMM; discards unsupported-length heads
//   ST_ISSUE | head command driven; stays while more issuable heads follow
// ----------------------------------------------------------------------------
module ccip_mmio_avmm_requestor
    import ccip_avmm_pkg::*;
#(
    parameter int REQ_FIFO_DEPTH    = 16,
    parameter int TID_FIFO_DEPTH    = 64,
    parameter int RD_TIMEOUT_CYCLES = 512
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  t_if_ccip_c0_Rx                       c0rx,
    output t_if_ccip_c2_Tx                       c2tx,
    output logic [CCIP_AVMM_MMIO_ADDR_WIDTH-1:0] avmm_address,
    output logic                                 avmm_read,
    output logic                                 avmm_write,
    output logic [63:0]                          avmm_writedata,
    output logic [7:0]                           avmm_byteenable,
    input  logic                                 avmm_waitrequest,
    input  logic [63:0]                          avmm_readdata,
    input  logic                                 avmm_readdatavalid,
    output logic                                 mmio_overflow
);

    t_ctl_state      state_q, state_d;
    t_mmio_req_entry req_wdata, req_head;
    t_mmio_tid_entry tid_wdata, tid_head;
    logic            req_push, req_pop, req_full, req_empty;
    logic            tid_push, tid_pop, tid_full, tid_empty;
    logic            c0_strobe;
    logic            issue_ok, discard, cmd_valid, accept;
    logic            tmo_fire, rsp_fire, upper_lane;
    logic            overflow_q, overflow_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [8:0]      rsp_tid_q, rsp_tid_d;
    logic [63:0]     rsp_data_q, rsp_data_d;

    // ---------------- request capture ----------------
    assign c0_strobe = c0rx.mmioRdValid || c0rx.mmioWrValid;
    assign req_push  = c0_strobe && !req_full;

    always_comb begin
        req_wdata.is_rd  = c0rx.mmioRdValid;
        req_wdata.addr   = c0rx.hdr.address;
        req_wdata.length = c0rx.hdr.length;
        req_wdata.tid    = c0rx.hdr.tid;
        req_wdata.data   = c0rx.data;
    end

    ccip_avmm_mmio_fifo #(
        .WIDTH ($bits(t_mmio_req_entry)),
        .DEPTH (REQ_FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (req_push),
        .wdata_i (req_wdata),
        .pop_i   (req_pop),
        .rdata_o (req_head),
        .full_o  (req_full),
        .empty_o (req_empty)
    );

    // ---------------- issue control ----------------
    // A read head blocks while the tid FIFO is full; a write behind it must
    // wait too, so ordering is only ever decided by the head.
    assign issue_ok  = !req_empty && mmio_len_supported(req_head.length) &&
                       !(req_head.is_rd && tid_full);
    assign discard   = (state_q == ST_IDLE) && !req_empty &&
                       !mmio_len_supported(req_head.length);
    assign cmd_valid = (state_q == ST_ISSUE) && issue_ok;
    assign accept    = cmd_valid && !avmm_waitrequest;
    assign req_pop   = accept || discard;
    assign tid_push  = accept && req_head.is_rd;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (issue_ok)  state_d = ST_ISSUE;
            ST_ISSUE: if (!issue_ok) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The head is stable until popped and tid_full cannot rise without an
    // accept, so a stalled command never changes under waitrequest.
    always_comb begin
        avmm_read       = 1'b0;
        avmm_write      = 1'b0;
        avmm_address    = '0;
        avmm_writedata  = '0;
        avmm_byteenable = '0;
        if (cmd_valid) begin
            avmm_read       = req_head.is_rd;
            avmm_write      = !req_head.is_rd;
            avmm_address    = {req_head.addr[15:1], 3'b000};
            avmm_byteenable = mmio_byteenable(req_head.addr[0], req_head.length);
            avmm_writedata  = (req_head.length == MMIO_LEN_4B) ?
                              {req_head.data[31:0], req_head.data[31:0]} :
                              req_head.data;
        end
    end

    assign overflow_d = overflow_q || (c0_strobe && req_full) || discard;

    // ---------------- outstanding reads ----------------
    assign tid_wdata = '{tid: req_head.tid, addr0: req_head.addr[0], length: req_head.length};

    ccip_avmm_mmio_fifo #(
        .WIDTH ($bits(t_mmio_tid_entry)),
        .DEPTH (TID_FIFO_DEPTH)
    ) u_tid_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (tid_push),
        .wdata_i (tid_wdata),
        .pop_i   (tid_pop),
        .rdata_o (tid_head),
        .full_o  (tid_full),
        .empty_o (tid_empty)
    );

`ifdef MMIO_RD_TIMEOUT_EN
    localparam int TMO_W = $clog2(RD_TIMEOUT_CYCLES) + 1;
    logic [TMO_W-1:0] tmo_q;

    // Down-counter reloaded whenever nothing is waiting or a response
    // arrives; reaching zero answers the oldest read on the slave's behalf.
    assign tmo_fire = !tid_empty && !avmm_readdatavalid && (tmo_q == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else if (tid_empty || avmm_readdatavalid || tmo_fire) begin
            tmo_q <= TMO_W'(RD_TIMEOUT_CYCLES - 1);
        end else begin
            tmo_q <= tmo_q - 1'b1;
        end
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (RD_TIMEOUT_CYCLES != 0);
    assign tmo_fire       = 1'b0;
`endif

    // readdatavalid with nothing outstanding (e.g. a read orphaned by reset)
    // is dropped here.
    assign rsp_fire   = (avmm_readdatavalid || tmo_fire) && !tid_empty;
    assign tid_pop    = rsp_fire;
    assign upper_lane = (tid_head.length == MMIO_LEN_4B) && tid_head.addr0;

    always_comb begin
        rsp_valid_d = rsp_fire;
        rsp_tid_d   = rsp_tid_q;
        rsp_data_d  = rsp_data_q;
        if (rsp_fire) begin
            rsp_tid_d = tid_head.tid;
            if (tmo_fire) begin
                rsp_data_d = '1;
            end else if (upper_lane) begin
                rsp_data_d = {32'h0, avmm_readdata[63:32]};
            end else begin
                rsp_data_d = avmm_readdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            overflow_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_tid_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            overflow_q  <= overflow_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tid_q   <= rsp_tid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign c2tx.hdr.tid     = rsp_tid_q;
    assign c2tx.mmioRdValid = rsp_valid_q;
    assign c2tx.data        = rsp_data_q;
    assign mmio_overflow    = overflow_q;

endmodule

// File: tb/tb_ccip_mmio_avmm_requestor.sv
module tb_ccip_mmio_avmm_requestor;
    import ccip_avmm_pkg::*;

    logic           clk = 1'b0;
    logic           reset_n;
    t_if_ccip_c0_Rx c0rx;
    t_if_ccip_c2_Tx c2tx;
    logic [17:0]    avmm_address;
    logic           avmm_read, avmm_write;
    logic [63:0]    avmm_writedata;
    logic [7:0]     avmm_byteenable;
    logic           avmm_waitrequest;
    logic [63:0]    avmm_readdata;
    logic           avmm_readdatavalid;
    logic           mmio_overflow;

    int n_vec = 0;
    int n_err = 0;

    logic [89:0] wr_q[$];   // {address, byteenable, writedata}
    logic [25:0] rd_q[$];   // {address, byteenable}
    logic [72:0] rsp_q[$];  // {tid, data}

    ccip_mmio_avmm_requestor dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .c0rx               (c0rx),
        .c2tx               (c2tx),
        .avmm_address       (avmm_address),
        .avmm_read          (avmm_read),
        .avmm_write         (avmm_write),
        .avmm_writedata     (avmm_writedata),
        .avmm_byteenable    (avmm_byteenable),
        .avmm_waitrequest   (avmm_waitrequest),
        .avmm_readdata      (avmm_readdata),
        .avmm_readdatavalid (avmm_readdatavalid),
        .mmio_overflow      (mmio_overflow)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1, so negedge sees settled values.
    always @(negedge clk) begin
        if (reset_n) begin
            if (avmm_write && !avmm_waitrequest)
                wr_q.push_back({avmm_address, avmm_byteenable, avmm_writedata});
            if (avmm_read && !avmm_waitrequest)
                rd_q.push_back({avmm_address, avmm_byteenable});
            if (c2tx.mmioRdValid)
                rsp_q.push_back({c2tx.hdr.tid, c2tx.data});
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic is_rd, input logic [15:0] addr, input logic [1:0] len,
                          input logic [8:0] tid, input logic [63:0] data);
        @(posedge clk); #1;
        c0rx.hdr.address = addr;
        c0rx.hdr.length  = len;
        c0rx.hdr.tid     = tid;
        c0rx.data        = data;
        c0rx.mmioRdValid = is_rd;
        c0rx.mmioWrValid = !is_rd;
    endtask

    task automatic c0_idle();
        @(posedge clk); #1;
        c0rx.mmioRdValid = 1'b0;
        c0rx.mmioWrValid = 1'b0;
    endtask

    task automatic slave_rsp(input logic [63:0] data);
        @(posedge clk); #1;
        avmm_readdatavalid = 1'b1;
        avmm_readdata      = data;
        @(posedge clk); #1;
        avmm_readdatavalid = 1'b0;
    endtask

    function automatic int qsize(input int which);
        case (which)
            0:       return wr_q.size();
            1:       return rd_q.size();
            default: return rsp_q.size();
        endcase
    endfunction

    task automatic wait_q(input int which, input int n, input int budget);
        int k = 0;
        while (qsize(which) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (qsize(which) < n) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_q%0d: observed %0d entries expected %0d", which, qsize(which), n);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset_n            = 1'b0;
        c0rx               = '0;
        avmm_waitrequest   = 1'b0;
        avmm_readdatavalid = 1'b0;
        avmm_readdata      = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        wr_q.delete();
        rd_q.delete();
        rsp_q.delete();
    endtask

    initial begin
        c0rx               = '0;
        avmm_waitrequest   = 1'b0;
        avmm_readdata      = '0;
        avmm_readdatavalid = 1'b0;
        reset_n            = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_read",   avmm_read, 0);
        chk("rst_write",  avmm_write, 0);
        chk("rst_c2vld",  c2tx.mmioRdValid, 0);
        chk("rst_ovf",    mmio_overflow, 0);
        chk("rst_addr",   avmm_address, 0);
        chk("rst_be",     avmm_byteenable, 0);
        chk("rst_wdata",  avmm_writedata, 0);
        @(posedge clk); #1 reset_n = 1'b1;

        // Writes: 8B, 4B upper lane, 4B lower lane
        strobe(1'b0, 16'h0010, MMIO_LEN_8B, 9'h0, 64'h1122_3344_5566_7788);
        strobe(1'b0, 16'h0011, MMIO_LEN_4B, 9'h0, 64'h0000_0000_DEAD_BEEF);
        strobe(1'b0, 16'h0012, MMIO_LEN_4B, 9'h0, 64'hFFFF_FFFF_1234_5678);
        c0_idle();
        wait_q(0, 3, 20);
        chk("wr_8b",    wr_q[0], {18'h00040, 8'hFF, 64'h1122_3344_5566_7788});
        chk("wr_4b_hi", wr_q[1], {18'h00040, 8'hF0, 64'hDEAD_BEEF_DEAD_BEEF});
        chk("wr_4b_lo", wr_q[2], {18'h00048, 8'h0F, 64'h1234_5678_1234_5678});

        // 4B upper-lane read, response one cycle after readdatavalid
        strobe(1'b1, 16'h0011, MMIO_LEN_4B, 9'h05, 64'h0);
        c0_idle();
        wait_q(1, 1, 20);
        chk("rd_4b_hi", rd_q[0], {18'h00040, 8'hF0});
        @(posedge clk); #1;
        avmm_readdatavalid = 1'b1;
        avmm_readdata      = 64'hAAAA_BBBB_CCCC_DDDD;
        @(negedge clk);
        chk("rsp_early", c2tx.mmioRdValid, 0);
        @(posedge clk); #1 avmm_readdatavalid = 1'b0;
        @(negedge clk);
        chk("rsp_vld",  c2tx.mmioRdValid, 1);
        chk("rsp_tid",  c2tx.hdr.tid, 9'h05);
        chk("rsp_data", c2tx.data, 64'h0000_0000_AAAA_BBBB);
        @(negedge clk);
        chk("rsp_once", c2tx.mmioRdValid, 0);

        // 8B read and 4B lower-lane read
        rsp_q.delete();
        strobe(1'b1, 16'h0020, MMIO_LEN_8B, 9'h1FF, 64'h0);
        strobe(1'b1, 16'h0022, MMIO_LEN_4B, 9'h00A, 64'h0);
        c0_idle();
        wait_q(1, 3, 20);
        chk("rd_8b",    rd_q[1], {18'h00080, 8'hFF});
        chk("rd_4b_lo", rd_q[2], {18'h00088, 8'h0F});
        slave_rsp(64'h0123_4567_89AB_CDEF);
        slave_rsp(64'hFEDC_BA98_7654_3210);
        wait_q(2, 2, 20);
        chk("rsp_8b",    rsp_q[0], {9'h1FF, 64'h0123_4567_89AB_CDEF});
        chk("rsp_4b_lo", rsp_q[1], {9'h00A, 64'hFEDC_BA98_7654_3210});
        chk("ovf_clear", mmio_overflow, 0);

        // 64B request is discarded
        strobe(1'b0, 16'h0030, MMIO_LEN_64B, 9'h0, 64'h1);
        c0_idle();
        repeat (10) @(negedge clk);
        chk("discard_nowr", wr_q.size(), 3);
        chk("discard_ovf",  mmio_overflow, 1);

        // 17 writes into a stalled 16-deep FIFO
        apply_reset();
        chk("ovf_after_rst", mmio_overflow, 0);
        avmm_waitrequest = 1'b1;
        for (int i = 0; i < 17; i++)
            strobe(1'b0, 16'h0100 + 16'(2 * i), MMIO_LEN_8B, 9'h0, 64'hA5A5_0000_0000_0000 | 64'(i));
        c0_idle();
        @(negedge clk);
        chk("stall_write", avmm_write, 1);
        chk("stall_addr",  avmm_address, 18'h00400);
        chk("stall_data",  avmm_writedata, 64'hA5A5_0000_0000_0000);
        chk("full_ovf",    mmio_overflow, 1);
        @(posedge clk); #1 avmm_waitrequest = 1'b0;
        wait_q(0, 16, 60);
        repeat (5) @(negedge clk);
        chk("n_wr_16", wr_q.size(), 16);
        for (int i = 0; i < 16; i++)
            chk("wr_order", wr_q[i], {18'h00400 + 18'(8 * i), 8'hFF, 64'hA5A5_0000_0000_0000 | 64'(i)});

        // 64 reads outstanding, 65th held back
        apply_reset();
        for (int i = 0; i < 65; i++)
            strobe(1'b1, 16'(2 * i), MMIO_LEN_8B, 9'(i), 64'h0);
        c0_idle();
        repeat (20) @(negedge clk);
        chk("n_rd_64",    rd_q.size(), 64);
        chk("rd_blocked", avmm_read, 0);
        chk("rd_ovf",     mmio_overflow, 0);
        slave_rsp(64'h5000_0000_0000_0000);
        wait_q(1, 65, 20);
        chk("rd_65th", rd_q[64], {18'h00200, 8'hFF});
        for (int i = 1; i < 65; i++)
            slave_rsp(64'h5000_0000_0000_0000 + 64'(i));
        wait_q(2, 65, 40);
        chk("n_rsp_65", rsp_q.size(), 65);
        for (int i = 0; i < 65; i++)
            chk("rsp_order", rsp_q[i], {9'(i), 64'h5000_0000_0000_0000 + 64'(i)});

        // Reset with reads outstanding, a stalled write and a live response
        apply_reset();
        strobe(1'b1, 16'h0040, MMIO_LEN_4B, 9'h1, 64'h0);
        strobe(1'b1, 16'h0042, MMIO_LEN_4B, 9'h2, 64'h0);
        strobe(1'b1, 16'h0044, MMIO_LEN_4B, 9'h3, 64'h0);
        c0_idle();
        wait_q(1, 3, 20);
        @(posedge clk); #1 avmm_waitrequest = 1'b1;
        strobe(1'b0, 16'h0050, MMIO_LEN_8B, 9'h0, 64'h77);
        c0_idle();
        repeat (3) @(negedge clk);
        chk("pre_rst_wr", avmm_write, 1);
        @(posedge clk); #1;
        avmm_readdatavalid = 1'b1;
        avmm_readdata      = 64'h99;
        @(posedge clk); #1 avmm_readdatavalid = 1'b0;
        #1 chk("pre_rst_rsp", c2tx.mmioRdValid, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_c2vld", c2tx.mmioRdValid, 0);
        chk("mid_rst_wr",    avmm_write, 0);
        chk("mid_rst_addr",  avmm_address, 0);
        chk("mid_rst_wdata", avmm_writedata, 0);
        @(posedge clk); #1 avmm_waitrequest = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        wr_q.delete();
        rd_q.delete();
        rsp_q.delete();
        repeat (3) slave_rsp(64'hDEAD_0000_0000_0001);
        repeat (10) @(negedge clk);
        chk("stray_no_rsp", rsp_q.size(), 0);
        chk("stray_no_wr",  wr_q.size(), 0);
        chk("stray_no_rd",  avmm_read, 0);

`ifdef MMIO_RD_TIMEOUT_EN
        apply_reset();
        strobe(1'b1, 16'h0060, MMIO_LEN_8B, 9'h07, 64'h0);
        c0_idle();
        repeat (400) @(negedge clk);
        chk("tmo_early", rsp_q.size(), 0);
        wait_q(2, 1, 300);
        chk("tmo_rsp", rsp_q[0], {9'h07, 64'hFFFF_FFFF_FFFF_FFFF});
`else
        apply_reset();
        strobe(1'b1, 16'h0060, MMIO_LEN_8B, 9'h07, 64'h0);
        c0_idle();
        repeat (600) @(negedge clk);
        chk("no_tmo", rsp_q.size(), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
